// File: rtl/cp0_regfile_if.sv
// Bundle between the M-stage pipeline and the CP0 register file: commit inputs,
// MTC0/MFC0 access and the live register values consumed by the prioritiser.
interface cp0_regfile_if;
  logic        stall;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [4:0]  raddr_i;
  logic [31:0] data_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [5:0]  int_i;
  logic [31:0] data_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic [31:0] count_o;
  logic [31:0] compare_o;
  logic [31:0] badvaddr_o;
  logic        timer_int_o;

  // No valid/ready pair: every input is sampled on each rising clk edge, and a
  // commit or MTC0 takes effect only on an edge where stall is low.
  modport master (
    output stall, we_i, waddr_i, raddr_i, data_i, excepttype_i, pc_i,
           is_in_delayslot_i, bad_addr_i, int_i,
    input  data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o,
           timer_int_o
  );

  modport slave (
    input  stall, we_i, waddr_i, raddr_i, data_i, excepttype_i, pc_i,
           is_in_delayslot_i, bad_addr_i, int_i,
    output data_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o,
           timer_int_o
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: commits prioritised exceptions, ERET and MTC0,
// serves MFC0 reads and runs the Count/Compare timer interrupt.
module cp0_regfile #(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int unsigned CNT_DIV    = 2
) (
  input logic          clk,
  input logic          resetn,
  cp0_regfile_if.slave bus
);
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam int unsigned PHASE_MAX    = CNT_DIV - 1;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_q, timer_d;
  logic        phase_q, phase_d;

  logic commit, exc_valid, is_eret, mtc0, tick;

  assign commit    = (bus.excepttype_i != 32'h0) && !bus.stall;
  assign exc_valid = bus.excepttype_i inside {32'h1, 32'h4, 32'h5, 32'h8,
                                              32'h9, 32'ha, 32'hc};
  assign is_eret   = (bus.excepttype_i == 32'he);
  assign mtc0      = bus.we_i && !bus.stall && !commit;
  assign tick      = (phase_q == PHASE_MAX[0]);

  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    timer_d    = timer_q;
    phase_d    = tick ? 1'b0 : phase_q + 1'b1;

    // Count and the timer keep running through stalls.
    if (mtc0 && bus.waddr_i == REG_COUNT) count_d = bus.data_i;
    else if (tick)                        count_d = count_q + 32'd1;

    if (count_q == compare_q && compare_q != 32'h0) timer_d = 1'b1;
    if (mtc0 && bus.waddr_i == REG_COMPARE)         timer_d = 1'b0;

    cause_d[15]    = bus.int_i[5] | timer_q;
    cause_d[14:10] = bus.int_i[4:0];

    if (commit) begin
      if (exc_valid) begin
        // A nested exception keeps the EPC/BD of the original fault.
        if (!status_q[1]) begin
          epc_d       = bus.is_in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
          cause_d[31] = bus.is_in_delayslot_i;
        end
        status_d[1]  = 1'b1;
        cause_d[6:2] = (bus.excepttype_i == 32'h1) ? 5'd0 : bus.excepttype_i[4:0];
        if (bus.excepttype_i == 32'h4 || bus.excepttype_i == 32'h5)
          badvaddr_d = bus.bad_addr_i;
      end else if (is_eret) begin
        status_d[1] = 1'b0;
      end
    end else if (mtc0) begin
      case (bus.waddr_i)
        REG_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK);
        REG_CAUSE:   cause_d[9:8] = bus.data_i[9:8];
        REG_EPC:     epc_d = bus.data_i;
        REG_COMPARE: compare_d = bus.data_i;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q   <= STATUS_RST;
      cause_q    <= 32'h0;
      epc_q      <= 32'h0;
      badvaddr_q <= 32'h0;
      count_q    <= 32'h0;
      compare_q  <= 32'h0;
      timer_q    <= 1'b0;
      phase_q    <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    bus.data_o = 32'h0;
    case (bus.raddr_i)
      REG_BADVADDR: bus.data_o = badvaddr_q;
      REG_COUNT:    bus.data_o = count_q;
      REG_COMPARE:  bus.data_o = compare_q;
      REG_STATUS:   bus.data_o = status_q;
      REG_CAUSE:    bus.data_o = cause_q;
      REG_EPC:      bus.data_o = epc_q;
      default:      bus.data_o = 32'h0;
    endcase
  end

  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.count_o     = count_q;
  assign bus.compare_o   = compare_q;
  assign bus.badvaddr_o  = badvaddr_q;
  assign bus.timer_int_o = timer_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: expectations are queued before each clock
// step and drained against the DUT outputs just after the edge.
module tb_cp0_regfile;
  localparam int CNT_DIV = 2;

  localparam logic [3:0] S_STATUS = 4'd0, S_CAUSE = 4'd1, S_EPC = 4'd2,
                         S_COUNT = 4'd3, S_COMPARE = 4'd4, S_BADV = 4'd5,
                         S_TIMER = 4'd6, S_DATA = 4'd7;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  cp0_regfile_if bus();

  cp0_regfile #(.STATUS_RST(32'h0040_0000), .CNT_DIV(CNT_DIV)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [3:0]  sel_q[$];
  string       tag_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // Timer reference state, advanced once per step from the driven inputs.
  logic [31:0] count_m = 32'h0, cmp_m = 32'h0;
  logic        timer_m = 1'b0;
  int          phase_m = 0;

  function automatic logic [31:0] observe(input logic [3:0] s);
    case (s)
      S_STATUS:  return bus.status_o;
      S_CAUSE:   return bus.cause_o;
      S_EPC:     return bus.epc_o;
      S_COUNT:   return bus.count_o;
      S_COMPARE: return bus.compare_o;
      S_BADV:    return bus.badvaddr_o;
      S_TIMER:   return {31'h0, bus.timer_int_o};
      default:   return bus.data_o;
    endcase
  endfunction

  task automatic expect_v(input logic [3:0] s, input logic [31:0] v, input string t);
    sel_q.push_back(s);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.we_i = 1'b0; bus.waddr_i = 5'd0; bus.data_i = 32'h0;
    bus.excepttype_i = 32'h0; bus.is_in_delayslot_i = 1'b0; bus.int_i = 6'h0;
  endtask

  task automatic model_edge();
    logic commit, mt, tick, t;
    logic [31:0] pre_count, pre_cmp;
    pre_count = count_m;
    pre_cmp   = cmp_m;
    if (!resetn) begin
      count_m = 32'h0; cmp_m = 32'h0; timer_m = 1'b0; phase_m = 0;
    end else begin
      commit = (bus.excepttype_i != 32'h0) && !bus.stall;
      mt     = bus.we_i && !bus.stall && !commit;
      tick   = (phase_m == CNT_DIV - 1);
      phase_m = tick ? 0 : phase_m + 1;
      if (mt && bus.waddr_i == 5'd9) count_m = bus.data_i;
      else if (tick)                 count_m = count_m + 32'd1;
      t = timer_m;
      if (pre_count == pre_cmp && pre_cmp != 32'h0) t = 1'b1;
      if (mt && bus.waddr_i == 5'd11) t = 1'b0;
      timer_m = t;
      if (mt && bus.waddr_i == 5'd11) cmp_m = bus.data_i;
    end
  endtask

  task automatic step();
    logic [31:0] obs, v;
    logic [3:0]  s;
    string       t;
    model_edge();
    @(posedge clk);
    #1;
    expect_v(S_COUNT, count_m, "count");
    expect_v(S_TIMER, {31'h0, timer_m}, "timer");
    expect_v(S_COMPARE, cmp_m, "compare");
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      obs = observe(s);
      tests_run++;
      assert (obs === v) else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", t, obs, v);
      end
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    bus.we_i = 1'b1; bus.waddr_i = a; bus.data_i = d;
  endtask

  task automatic exc(input logic [31:0] code, input logic [31:0] pc,
                     input logic ds, input logic [31:0] bad);
    idle();
    bus.excepttype_i = code; bus.pc_i = pc; bus.is_in_delayslot_i = ds;
    bus.bad_addr_i = bad;
  endtask

  initial begin
    logic [31:0] c_exp;
    idle();
    bus.raddr_i = 5'd12; bus.pc_i = 32'h0; bus.bad_addr_i = 32'h0;

    // Reset held for two edges
    resetn = 1'b0;
    step();
    expect_v(S_STATUS, 32'h0040_0000, "rst_status");
    expect_v(S_CAUSE, 32'h0, "rst_cause");
    expect_v(S_EPC, 32'h0, "rst_epc");
    expect_v(S_BADV, 32'h0, "rst_badv");
    expect_v(S_DATA, 32'h0040_0000, "rst_mfc0_status");
    step();
    resetn = 1'b1;

    // Syscall then ERET
    exc(32'h8, 32'hBFC0_1000, 1'b0, 32'h0);
    expect_v(S_EPC, 32'hBFC0_1000, "sys_epc");
    expect_v(S_CAUSE, 32'h0000_0020, "sys_cause");
    expect_v(S_STATUS, 32'h0040_0002, "sys_status");
    step();
    exc(32'he, 32'h0, 1'b0, 32'h0);
    expect_v(S_STATUS, 32'h0040_0000, "eret_status");
    expect_v(S_EPC, 32'hBFC0_1000, "eret_epc");
    step();

    // AdEL in delay slot, then nested exception while EXL=1
    exc(32'h4, 32'h8000_0104, 1'b1, 32'h0000_0003);
    expect_v(S_EPC, 32'h8000_0100, "adel_epc");
    expect_v(S_CAUSE, 32'h8000_0010, "adel_cause");
    expect_v(S_BADV, 32'h0000_0003, "adel_badv");
    step();
    exc(32'hc, 32'h1234_0000, 1'b0, 32'hFFFF_FFFF);
    expect_v(S_EPC, 32'h8000_0100, "nest_epc");
    expect_v(S_CAUSE, 32'h8000_0030, "nest_cause");
    expect_v(S_BADV, 32'h0000_0003, "nest_badv");
    step();
    exc(32'he, 32'h0, 1'b0, 32'h0);
    expect_v(S_STATUS, 32'h0040_0000, "eret2_status");
    step();

    // Code 1 reports ExcCode 0
    exc(32'h1, 32'h0000_0040, 1'b0, 32'h0);
    expect_v(S_EPC, 32'h0000_0040, "int_epc");
    expect_v(S_CAUSE, 32'h0, "int_cause");
    expect_v(S_STATUS, 32'h0040_0002, "int_status");
    step();
    exc(32'he, 32'h0, 1'b0, 32'h0);
    step();

    // Unsupported code: no change, and it still suppresses the MTC0
    exc(32'h3, 32'h5555_0000, 1'b0, 32'h0);
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.data_i = 32'hAAAA_AAAA;
    expect_v(S_EPC, 32'h0000_0040, "code3_epc");
    expect_v(S_STATUS, 32'h0040_0000, "code3_status");
    step();

    // Write masking
    mtc0(5'd12, 32'hFFFF_FFFF);
    expect_v(S_STATUS, 32'h0040_FF03, "mask_status");
    expect_v(S_DATA, 32'h0040_FF03, "mask_mfc0_status");
    step();
    mtc0(5'd12, 32'h0);
    expect_v(S_STATUS, 32'h0040_0000, "clr_status");
    step();
    mtc0(5'd13, 32'hFFFF_FFFF);
    expect_v(S_CAUSE, 32'h0000_0300, "mask_cause");
    step();
    mtc0(5'd13, 32'h0);
    expect_v(S_CAUSE, 32'h0, "clr_cause");
    step();
    mtc0(5'd8, 32'hDEAD_BEEF);
    bus.raddr_i = 5'd8;
    expect_v(S_BADV, 32'h0000_0003, "ro_badv");
    expect_v(S_DATA, 32'h0000_0003, "mfc0_badv");
    step();
    mtc0(5'd14, 32'h1234_5678);
    bus.raddr_i = 5'd14;
    expect_v(S_EPC, 32'h1234_5678, "mtc0_epc");
    expect_v(S_DATA, 32'h1234_5678, "mfc0_epc");
    step();
    idle();
    bus.raddr_i = 5'd5;
    bus.int_i = 6'b100001;
    expect_v(S_CAUSE, 32'h0000_8400, "hw_ip");
    expect_v(S_DATA, 32'h0, "mfc0_unmapped");
    step();
    idle();
    bus.raddr_i = 5'd12;
    expect_v(S_CAUSE, 32'h0, "hw_ip_clear");
    step();

    // Exception beats a simultaneous MTC0 Status
    exc(32'h9, 32'h0000_0100, 1'b0, 32'h0);
    bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.data_i = 32'h0;
    expect_v(S_STATUS, 32'h0040_0002, "prio_status");
    expect_v(S_EPC, 32'h0000_0100, "prio_epc");
    expect_v(S_CAUSE, 32'h0000_0024, "prio_cause");
    step();
    exc(32'he, 32'h0, 1'b0, 32'h0);
    step();

    // Stall blocks commits, Count keeps running
    for (int i = 0; i < 3; i++) begin
      exc(32'h8, 32'h0000_0999, 1'b1, 32'h0000_0077);
      bus.stall = 1'b1;
      expect_v(S_STATUS, 32'h0040_0000, "stall_status");
      expect_v(S_EPC, 32'h0000_0100, "stall_epc");
      expect_v(S_CAUSE, 32'h0000_0024, "stall_cause");
      expect_v(S_BADV, 32'h0000_0003, "stall_badv");
      step();
    end

    // Timer: Compare=5, Count=0, wait for the sticky interrupt
    mtc0(5'd11, 32'd5);
    step();
    mtc0(5'd9, 32'd0);
    step();
    for (int i = 0; i < 14; i++) begin
      idle();
      c_exp = 32'h0000_0024 | (timer_m ? 32'h0000_8000 : 32'h0);
      expect_v(S_CAUSE, c_exp, "timer_ip");
      step();
    end
    idle();
    expect_v(S_TIMER, 32'h1, "timer_fired");
    expect_v(S_CAUSE, 32'h0000_8024, "timer_cause15");
    step();
    mtc0(5'd11, 32'd20);
    expect_v(S_TIMER, 32'h0, "timer_clear");
    expect_v(S_COMPARE, 32'd20, "compare_write");
    step();
    idle();
    expect_v(S_CAUSE, 32'h0000_0024, "timer_cause_clear");
    step();

    // Reset mid-operation
    resetn = 1'b0;
    exc(32'h8, 32'hFFFF_0000, 1'b0, 32'h0);
    expect_v(S_STATUS, 32'h0040_0000, "rst2_status");
    expect_v(S_EPC, 32'h0, "rst2_epc");
    expect_v(S_CAUSE, 32'h0, "rst2_cause");
    step();
    resetn = 1'b1;
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
